pc_unit: RTL and testbench

- Program-counter stage of the single-cycle MIPS core; sits directly upstream of the instruction decoder and control unit.
- Holds the PC register and supplies PC/PC+4 to instruction memory and the datapath.
- Selects the next PC from the control unit's 3-bit PCSrc code (0 seq, 1 branch, 2 jump, 3 jr/jalr, 4 interrupt, 5 illegal-instruction exception).
- Edge-detects and latches the external timer interrupt, and produces the masked IRQ fed to the control unit. The interrupt is masked while in kernel mode (PC[31]=1).

---
 rtl/pc_if.sv | 25 ++
 rtl/pc_unit.sv | 68 ++++++
 tb/tb_pc_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pc_if.sv
// Bus between the program-counter stage and the control unit/datapath.
// The master drives PC selection and operands; the slave (pc_unit) returns PC values and IRQ.
interface pc_if;
  logic [2:0]  PCSrc;
  logic        ALUOut0;
  logic [15:0] Imm16;
  logic [25:0] JT;
  logic [31:0] DatabusA;
  logic        ExtIRQ;
  logic        Stall;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] ConBA;
  logic        IRQ;

  modport master (
    output PCSrc, ALUOut0, Imm16, JT, DatabusA, ExtIRQ, Stall,
    input  PC, PCPlus4, ConBA, IRQ
  );

  modport slave (
    input  PCSrc, ALUOut0, Imm16, JT, DatabusA, ExtIRQ, Stall,
    output PC, PCPlus4, ConBA, IRQ
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter stage of the single-cycle MIPS core: PC register, next-PC mux,
// and the edge-detected timer interrupt latch masked while in kernel mode (PC[31]=1).
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] IRQ_PC   = 32'h8000_0004,
  parameter logic [31:0] EXC_PC   = 32'h8000_0008
) (
  input  logic clk,
  input  logic reset,
  pc_if.slave  bus
);

  logic [31:0] r_pc;
  logic        r_irq_pending;
  logic        r_extirq_d;

  logic [31:0] w_pc_plus4;
  logic [30:0] w_br_off;
  logic [31:0] w_con_ba;
  logic [31:0] w_jump;
  logic [31:0] w_next_pc;
  logic        w_rise;
  logic        w_irq_clr;

  // Bit 31 is the kernel-mode flag; only jr/jalr and the vectors may change it.
  assign w_pc_plus4 = {r_pc[31], r_pc[30:0] + 31'd4};
  assign w_br_off   = {{13{bus.Imm16[15]}}, bus.Imm16, 2'b00};
  assign w_con_ba   = {w_pc_plus4[31], w_pc_plus4[30:0] + w_br_off};
  assign w_jump     = {w_pc_plus4[31:28], bus.JT, 2'b00};

  always_comb begin
    w_next_pc = EXC_PC;
    case (bus.PCSrc)
      3'd0:    w_next_pc = w_pc_plus4;
      3'd1:    w_next_pc = bus.ALUOut0 ? w_con_ba : w_pc_plus4;
      3'd2:    w_next_pc = w_jump;
      3'd3:    w_next_pc = bus.DatabusA;
      3'd4:    w_next_pc = IRQ_PC;
      default: w_next_pc = EXC_PC;
    endcase
  end

  assign w_rise    = bus.ExtIRQ & ~r_extirq_d;
  assign w_irq_clr = (bus.PCSrc == 3'd4) & ~bus.Stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_irq_pending <= 1'b0;
      r_extirq_d    <= 1'b0;
    end else begin
      r_extirq_d <= bus.ExtIRQ;
      if (!bus.Stall)
        r_pc <= w_next_pc;
      // A new edge in the same cycle as the handler entry must not be lost.
      if (w_rise)
        r_irq_pending <= 1'b1;
      else if (w_irq_clr)
        r_irq_pending <= 1'b0;
    end
  end

  assign bus.PC      = r_pc;
  assign bus.PCPlus4 = w_pc_plus4;
  assign bus.ConBA   = w_con_ba;
  assign bus.IRQ     = r_irq_pending & ~r_pc[31];

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; expected values are hand-computed constants.
module tb_pc_unit;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   irq_rises;
  logic irq_prev;

  pc_if bus ();

  pc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jr(input logic [31:0] addr);
    bus.PCSrc    = 3'd3;
    bus.DatabusA = addr;
    step();
    bus.PCSrc    = 3'd0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset        = 1'b0;
    bus.PCSrc    = 3'd0;
    bus.ALUOut0  = 1'b0;
    bus.Imm16    = 16'h0000;
    bus.JT       = 26'h0;
    bus.DatabusA = 32'h0;
    bus.ExtIRQ   = 1'b0;
    bus.Stall    = 1'b0;

    step();
    step();
    chk("reset_pc", bus.PC, 32'h8000_0000);
    chk("reset_irq", {31'd0, bus.IRQ}, 32'd0);
    chk("reset_pcplus4", bus.PCPlus4, 32'h8000_0004);

    reset = 1'b1;
    step();
    chk("seq1_pc", bus.PC, 32'h8000_0004);
    chk("seq1_irq", {31'd0, bus.IRQ}, 32'd0);
    step();
    chk("seq2_pc", bus.PC, 32'h8000_0008);
    step();
    chk("seq3_pc", bus.PC, 32'h8000_000C);
    chk("seq3_irq", {31'd0, bus.IRQ}, 32'd0);

    // Branch taken / not taken from 0x100 with offset -2 words
    jr(32'h0000_0100);
    chk("jr_100", bus.PC, 32'h0000_0100);
    bus.PCSrc = 3'd1; bus.Imm16 = 16'hFFFE; bus.ALUOut0 = 1'b1;
    #1;
    chk("conba_neg", bus.ConBA, 32'h0000_00FC);
    step();
    chk("br_taken", bus.PC, 32'h0000_00FC);
    jr(32'h0000_0100);
    bus.PCSrc = 3'd1; bus.ALUOut0 = 1'b0;
    step();
    chk("br_not_taken", bus.PC, 32'h0000_0104);

    // Jump, jr and wrap
    jr(32'h0000_1000);
    bus.PCSrc = 3'd2; bus.JT = 26'h000_0040;
    step();
    chk("jump", bus.PC, 32'h0000_0100);
    jr(32'h8000_0010);
    chk("jr_kernel", bus.PC, 32'h8000_0010);
    jr(32'h0040_0000);
    chk("jr_user", bus.PC, 32'h0040_0000);
    jr(32'h7FFF_FFFC);
    chk("wrap_pcplus4_user", bus.PCPlus4, 32'h0000_0000);
    step();
    chk("wrap_pc_user", bus.PC, 32'h0000_0000);
    jr(32'hFFFF_FFFC);
    chk("wrap_pcplus4_kernel", bus.PCPlus4, 32'h8000_0000);

    // Interrupt masked in kernel, presented after return to user mode
    jr(32'h8000_0020);
    bus.ExtIRQ = 1'b1;
    #1;
    chk("irq_no_comb_path", {31'd0, bus.IRQ}, 32'd0);
    step();
    chk("irq_masked_kernel1", {31'd0, bus.IRQ}, 32'd0);
    bus.ExtIRQ = 1'b0;
    step();
    chk("irq_masked_kernel2", {31'd0, bus.IRQ}, 32'd0);
    jr(32'h0000_0200);
    chk("jr_200", bus.PC, 32'h0000_0200);
    chk("irq_user", {31'd0, bus.IRQ}, 32'd1);
    bus.PCSrc = 3'd4;
    step();
    bus.PCSrc = 3'd0;
    chk("irq_vector", bus.PC, 32'h8000_0004);
    chk("irq_after_take", {31'd0, bus.IRQ}, 32'd0);
    jr(32'h0000_0300);
    chk("irq_cleared", {31'd0, bus.IRQ}, 32'd0);

    // Held level gives a single assertion
    irq_rises = 0;
    irq_prev  = 1'b0;
    bus.ExtIRQ = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.PCSrc = (i == 1) ? 3'd4 : (i == 2) ? 3'd3 : 3'd0;
      bus.DatabusA = 32'h0000_0400;
      step();
      if (bus.IRQ && !irq_prev) irq_rises++;
      irq_prev = bus.IRQ;
    end
    bus.PCSrc = 3'd0;
    chk("held_level_rises", irq_rises, 32'd1);
    chk("held_level_final", {31'd0, bus.IRQ}, 32'd0);

    // Set wins over the clear in the same cycle
    bus.ExtIRQ = 1'b0;
    step();
    bus.ExtIRQ = 1'b1;
    bus.PCSrc  = 3'd4;
    step();
    chk("setwin_pc", bus.PC, 32'h8000_0004);
    jr(32'h0000_0500);
    chk("setwin_irq", {31'd0, bus.IRQ}, 32'd1);

    // Stall holds PC and blocks the interrupt-taken clear
    bus.Stall = 1'b1;
    bus.PCSrc = 3'd2;
    bus.JT    = 26'h0_0123;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", bus.PC, 32'h0000_0500);
    end
    bus.PCSrc = 3'd4;
    step();
    chk("stall_pc_irqsel", bus.PC, 32'h0000_0500);
    chk("stall_no_clear", {31'd0, bus.IRQ}, 32'd1);
    bus.Stall = 1'b0;

    // Exception and reserved codes
    bus.PCSrc = 3'd5;
    step();
    chk("exc_5", bus.PC, 32'h8000_0008);
    jr(32'h0000_0600);
    bus.PCSrc = 3'd6;
    step();
    chk("exc_6", bus.PC, 32'h8000_0008);
    jr(32'h0000_0600);
    bus.PCSrc = 3'd7;
    step();
    chk("exc_7", bus.PC, 32'h8000_0008);

    // Reset mid-stall discards pending interrupt
    jr(32'h0000_0700);
    chk("pre_reset_irq", {31'd0, bus.IRQ}, 32'd1);
    bus.ExtIRQ = 1'b0;
    bus.Stall  = 1'b1;
    bus.PCSrc  = 3'd2;
    reset      = 1'b0;
    step();
    chk("reset_stall_pc", bus.PC, 32'h8000_0000);
    chk("reset_stall_irq", {31'd0, bus.IRQ}, 32'd0);
    reset     = 1'b1;
    bus.Stall = 1'b0;
    jr(32'h0000_0800);
    chk("reset_discard_pc", bus.PC, 32'h0000_0800);
    chk("reset_discard_irq", {31'd0, bus.IRQ}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
